icmp_echo_request_gen: RTL and testbench

Initiator side of ICMP echo: builds ICMP Echo Request messages (type 8) on the TX clock and streams them into the stack's ICMP transmit AXIS port of the Ethernet frame transmitter. The stack adds IP and MAC framing. After sending, the block waits for the matching Echo Reply, which the RX path reports as a decoded id/seq strobe that has already been synchronised into this clock domain. It then reports round-trip time or a timeout, so the design can ping a peer as well as answer pings.

---
 rtl/icmp_echo_request_gen.sv | 193 +++++++++++++++++++
 tb/tb_icmp_echo_request_gen.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icmp_echo_request_gen.sv
// icmp_echo_request_gen: builds ICMP Echo Request messages on AXIS and times the matching Echo Reply
// Ports:
//   tx_axis_aclk / tx_axis_aresetn   clock, asynchronous active-low reset
//   mac_exist, ping_start            request gate and one-cycle start pulse
//   ping_id, ping_len                identifier and payload length (clamped to 1472) sampled on start
//   icmp_tx_axis_*                   64-bit AXIS message stream, byte 0 in tdata[7:0]
//   reply_valid/reply_id/reply_seq   decoded Echo Reply strobe from the RX path
//   ping_busy, ping_seq              activity flag and sequence number of the current/last request
//   ping_done, ping_timeout          one-cycle result pulses
//   ping_rtt                         round-trip time in clocks of the last matched reply
module icmp_echo_request_gen #(
    parameter int unsigned TIMEOUT_CYCLES = 156250000
) (
    input  logic        tx_axis_aclk,
    input  logic        tx_axis_aresetn,
    input  logic        mac_exist,
    input  logic        ping_start,
    input  logic [15:0] ping_id,
    input  logic [10:0] ping_len,
    output logic [63:0] icmp_tx_axis_tdata,
    output logic [7:0]  icmp_tx_axis_tkeep,
    output logic        icmp_tx_axis_tvalid,
    output logic        icmp_tx_axis_tlast,
    input  logic        icmp_tx_axis_tready,
    input  logic        reply_valid,
    input  logic [15:0] reply_id,
    input  logic [15:0] reply_seq,
    output logic        ping_busy,
    output logic [15:0] ping_seq,
    output logic        ping_done,
    output logic        ping_timeout,
    output logic [31:0] ping_rtt
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_FOLD = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [10:0] MAX_LEN = 11'd1472;

    logic [2:0]  state_q, state_d;
    logic [15:0] seq_cnt_q, seq_cnt_d;
    logic [15:0] seq_q, seq_d;
    logic [15:0] id_q, id_d;
    logic [10:0] len_q, len_d;
    logic [7:0]  beat_q, beat_d;
    logic [31:0] sum_q, sum_d;
    logic [15:0] cksum_q, cksum_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] rtt_q, rtt_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;

    logic [7:0]  n_beats;
    logic [31:0] total;
    logic [16:0] fold1;
    logic [15:0] fold2;
    logic [63:0] header;
    logic        tx_last;
    logic        match;

    // Payload byte k is k[7:0]; bytes at or past len read as zero.
    function automatic logic [63:0] payload(input logic [7:0] p, input logic [10:0] len);
        logic [63:0] d;
        logic [10:0] k;
        d = '0;
        for (int j = 0; j < 8; j++) begin
            k = {p, 3'(j)};
            d[8*j+:8] = (k < len) ? k[7:0] : 8'h00;
        end
        return d;
    endfunction

    // Big-endian 16-bit words: the earlier byte on the wire is the high byte.
    function automatic logic [17:0] beat_sum(input logic [63:0] d);
        logic [17:0] s;
        s = '0;
        for (int w = 0; w < 4; w++)
            s = s + 18'({d[16*w+:8], d[16*w+8+:8]});
        return s;
    endfunction

    assign n_beats = 8'((len_q + 11'd7) >> 3);
    assign tx_last = beat_q == n_beats;
    assign match   = reply_valid && reply_id == id_q && reply_seq == seq_q;
    assign total   = sum_q + 32'h0000_0800 + 32'(id_q) + 32'(seq_q);
    assign fold1   = {1'b0, total[15:0]} + {1'b0, total[31:16]};
    assign fold2   = fold1[15:0] + {15'd0, fold1[16]};
    assign header  = {seq_q[7:0], seq_q[15:8], id_q[7:0], id_q[15:8],
                      cksum_q[7:0], cksum_q[15:8], 8'h00, 8'h08};

    assign icmp_tx_axis_tvalid = state_q == S_SEND;
    assign icmp_tx_axis_tlast  = icmp_tx_axis_tvalid && tx_last;
    assign icmp_tx_axis_tdata  = !icmp_tx_axis_tvalid ? 64'd0 :
                                 beat_q == 8'd0 ? header : payload(beat_q - 8'd1, len_q);
    assign icmp_tx_axis_tkeep  = !icmp_tx_axis_tvalid ? 8'h00 :
                                 (tx_last && beat_q != 8'd0 && len_q[2:0] != 3'd0) ?
                                 (8'd1 << len_q[2:0]) - 8'd1 : 8'hFF;
    assign ping_busy    = state_q != S_IDLE;
    assign ping_seq     = seq_q;
    assign ping_done    = done_q;
    assign ping_timeout = timeout_q;
    assign ping_rtt     = rtt_q;

    always_comb begin
        state_d   = state_q;
        seq_cnt_d = seq_cnt_q;
        seq_d     = seq_q;
        id_d      = id_q;
        len_d     = len_q;
        beat_d    = beat_q;
        sum_d     = sum_q;
        cksum_d   = cksum_q;
        cnt_d     = cnt_q;
        rtt_d     = rtt_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The result-pulse cycle is already IDLE but must not accept a start.
                if (ping_start && mac_exist && !done_q && !timeout_q) begin
                    id_d      = ping_id;
                    len_d     = (ping_len > MAX_LEN) ? MAX_LEN : ping_len;
                    seq_d     = seq_cnt_q;
                    seq_cnt_d = seq_cnt_q + 16'd1;
                    beat_d    = 8'd0;
                    sum_d     = 32'd0;
                    state_d   = (ping_len != 11'd0) ? S_CALC : S_FOLD;
                end
            end
            S_CALC: begin
                sum_d  = sum_q + 32'(beat_sum(payload(beat_q, len_q)));
                beat_d = (beat_q == n_beats - 8'd1) ? 8'd0 : beat_q + 8'd1;
                state_d = (beat_q == n_beats - 8'd1) ? S_FOLD : S_CALC;
            end
            S_FOLD: begin
                cksum_d = ~fold2;
                beat_d  = 8'd0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (icmp_tx_axis_tready) begin
                    beat_d  = tx_last ? beat_q : beat_q + 8'd1;
                    cnt_d   = tx_last ? 32'd0 : cnt_q;
                    state_d = tx_last ? S_WAIT : S_SEND;
                end
            end
            S_WAIT: begin
                if (match) begin
                    rtt_d   = cnt_q + 32'd1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
        if (!tx_axis_aresetn) begin
            state_q   <= S_IDLE;
            seq_cnt_q <= '0;
            seq_q     <= '0;
            id_q      <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            sum_q     <= '0;
            cksum_q   <= '0;
            cnt_q     <= '0;
            rtt_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seq_cnt_q <= seq_cnt_d;
            seq_q     <= seq_d;
            id_q      <= id_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            sum_q     <= sum_d;
            cksum_q   <= cksum_d;
            cnt_q     <= cnt_d;
            rtt_q     <= rtt_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end
endmodule

// File: tb/tb_icmp_echo_request_gen.sv
// tb_icmp_echo_request_gen: directed bench with a byte-level frame model and a per-cycle stream/pulse checker
module tb_icmp_echo_request_gen;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mac_exist = 1'b1;
    logic        ping_start = 1'b0;
    logic [15:0] ping_id = '0;
    logic [10:0] ping_len = '0;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid, tlast;
    logic        tready = 1'b1;
    logic        reply_valid = 1'b0;
    logic [15:0] reply_id = '0;
    logic [15:0] reply_seq = '0;
    logic        ping_busy;
    logic [15:0] ping_seq;
    logic        ping_done, ping_timeout;
    logic [31:0] ping_rtt;

    always #5 clk = ~clk;

    icmp_echo_request_gen #(.TIMEOUT_CYCLES(TO)) dut (
        .tx_axis_aclk(clk), .tx_axis_aresetn(rst_n), .mac_exist(mac_exist),
        .ping_start(ping_start), .ping_id(ping_id), .ping_len(ping_len),
        .icmp_tx_axis_tdata(tdata), .icmp_tx_axis_tkeep(tkeep),
        .icmp_tx_axis_tvalid(tvalid), .icmp_tx_axis_tlast(tlast),
        .icmp_tx_axis_tready(tready), .reply_valid(reply_valid),
        .reply_id(reply_id), .reply_seq(reply_seq), .ping_busy(ping_busy),
        .ping_seq(ping_seq), .ping_done(ping_done), .ping_timeout(ping_timeout),
        .ping_rtt(ping_rtt)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] q_data[$];
    logic [7:0]  q_keep[$];
    logic        q_last[$];
    int exp_done_cyc = -1;
    int exp_to_cyc = -1;
    int hs_cyc = 0;
    int frames = 0;
    int beats_in = 0;
    int last_beats = 0;
    logic in_frame = 1'b0;
    logic [15:0] m_seq = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: lay the whole message out as bytes, checksum it with a plain
    // 16-bit word sum, then cut it into 8-byte beats.
    task automatic build_frame(input logic [15:0] id, input int len_in, input logic [15:0] seq);
        logic [7:0] b[$];
        int unsigned s;
        int L, nb;
        logic [15:0] ck;
        logic [63:0] d;
        logic [7:0] k;
        L = (len_in > 1472) ? 1472 : len_in;
        b.push_back(8'h08); b.push_back(8'h00); b.push_back(8'h00); b.push_back(8'h00);
        b.push_back(id[15:8]); b.push_back(id[7:0]); b.push_back(seq[15:8]); b.push_back(seq[7:0]);
        for (int i = 0; i < L; i++) b.push_back(8'(i));
        s = 0;
        for (int i = 0; i < b.size(); i += 2)
            s += 32'({b[i], (i + 1 < b.size()) ? b[i+1] : 8'h00});
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        ck = ~s[15:0];
        b[2] = ck[15:8];
        b[3] = ck[7:0];
        nb = (b.size() + 7) / 8;
        for (int i = 0; i < nb; i++) begin
            d = '0;
            k = '0;
            for (int j = 0; j < 8; j++)
                if (8 * i + j < b.size()) begin
                    d[8*j+:8] = b[8*i+j];
                    k[j] = 1'b1;
                end
            q_data.push_back(d);
            q_keep.push_back(k);
            q_last.push_back(i == nb - 1);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q_data.delete();
            q_keep.delete();
            q_last.delete();
            in_frame = 1'b0;
            beats_in = 0;
        end else begin
            if (tvalid) begin
                if (q_data.size() == 0) check("unexpected_beat", 1, 0);
                else begin
                    check("tdata", tdata, q_data[0]);
                    check("tkeep", tkeep, q_keep[0]);
                    check("tlast", tlast, q_last[0]);
                    if (tready) begin
                        beats_in++;
                        in_frame = !q_last[0];
                        if (q_last[0]) begin
                            hs_cyc = cyc;
                            frames++;
                            last_beats = beats_in;
                            beats_in = 0;
                        end
                        void'(q_data.pop_front());
                        void'(q_keep.pop_front());
                        void'(q_last.pop_front());
                    end else in_frame = 1'b1;
                end
            end else if (in_frame) check("tvalid_held_mid_frame", 0, 1);
            check("ping_done", ping_done, cyc == exp_done_cyc);
            check("ping_timeout", ping_timeout, cyc == exp_to_cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic start(input logic [15:0] id, input int len, input bit accept);
        ping_id = id;
        ping_len = 11'(len);
        ping_start = 1'b1;
        if (accept) begin
            build_frame(id, len, m_seq);
            m_seq++;
        end
        tick(1);
        ping_start = 1'b0;
    endtask

    task automatic reply(input logic [15:0] id, input logic [15:0] seq);
        reply_id = id;
        reply_seq = seq;
        reply_valid = 1'b1;
        tick(1);
        reply_valid = 1'b0;
    endtask

    task automatic wait_tvalid(input string name, input int t0, input int lat);
        while (!tvalid && cyc < t0 + 50) tick(1);
        check(name, cyc - t0, lat);
    endtask

    // Alternating 0,0,1 tready when stall is set.
    task automatic wait_frame(input int target, input int budget, input bit stall);
        int n = 0;
        while (frames < target && n < budget) begin
            tready = stall ? (n % 3 == 2) : 1'b1;
            tick(1);
            n++;
        end
        tready = 1'b1;
        check("frame_complete_in_budget", frames >= target, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_done_cyc = -1;
        exp_to_cyc = -1;
        #1;
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tkeep", tkeep, 0);
        check("rst_tdata", tdata, 0);
        check("rst_busy", ping_busy, 0);
        check("rst_seq", ping_seq, 0);
        check("rst_rtt", ping_rtt, 0);
        check("rst_pulses", {ping_done, ping_timeout}, 0);
        m_seq = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        int t0, tgt;
        tick(2);
        do_reset();

        // len=0: single header beat, then timeout with no reply.
        t0 = cyc;
        tgt = frames + 1;
        start(16'h1234, 0, 1);
        wait_tvalid("A_first_tvalid", t0, 2);
        check("A_tdata", tdata, 64'h0000_3412_CBE5_0008);
        check("A_tkeep", tkeep, 8'hFF);
        check("A_tlast", tlast, 1);
        wait_frame(tgt, 50, 0);
        exp_to_cyc = hs_cyc + TO + 1;
        tick_to(exp_to_cyc + 1);
        check("A_rtt_unchanged", ping_rtt, 0);
        check("A_idle", ping_busy, 0);
        reply(16'h1234, 16'h0000);
        tick(3);
        check("A_seq", ping_seq, 0);

        // len=4: literal checksum/payload; wrong-seq reply ignored, match after 5.
        do_reset();
        t0 = cyc;
        tgt = frames + 1;
        start(16'h1234, 4, 1);
        wait_tvalid("B_first_tvalid", t0, 3);
        check("B_beat0", tdata, 64'h0000_3412_C7E3_0008);
        tick(1);
        check("B_beat1", tdata, 64'h0000_0000_0302_0100);
        check("B_keep1", tkeep, 8'h0F);
        check("B_last1", tlast, 1);
        wait_frame(tgt, 50, 0);
        tick_to(hs_cyc + 2);
        reply(16'h1234, 16'h0005);
        tick_to(hs_cyc + 5);
        exp_done_cyc = hs_cyc + 6;
        reply(16'h1234, 16'h0000);
        tick(1);
        check("B_rtt", ping_rtt, 5);
        check("B_idle", ping_busy, 0);

        // mac_exist low: start ignored.
        mac_exist = 1'b0;
        start(16'h7777, 4, 0);
        tick(1);
        check("C_no_start", ping_busy, 0);
        mac_exist = 1'b1;

        // len=8 with stalls; start while busy ignored; reply in first WAIT cycle.
        tgt = frames + 1;
        start(16'h0000, 8, 1);
        check("D_seq", ping_seq, 1);
        check("D_busy", ping_busy, 1);
        start(16'h5555, 3, 0);
        check("D_seq_after_busy_start", ping_seq, 1);
        wait_frame(tgt, 200, 1);
        check("D_beats", last_beats, 2);
        exp_done_cyc = cyc + 1;
        reply(16'h0000, 16'h0001);
        start(16'h6666, 5, 0);
        check("D_start_on_done_ignored", ping_busy, 0);
        check("D_rtt", ping_rtt, 1);
        check("D_seq_kept", ping_seq, 1);

        // Reply on the tlast handshake is ignored; match beats timeout in the same cycle.
        t0 = cyc;
        start(16'hBEEF, 0, 1);
        tick_to(t0 + 2);
        reply(16'hBEEF, 16'h0002);
        check("E_hs_cyc", hs_cyc, t0 + 2);
        tick_to(t0 + 2 + TO);
        exp_done_cyc = t0 + 3 + TO;
        reply(16'hBEEF, 16'h0002);
        tick(1);
        check("E_rtt", ping_rtt, TO);

        // len=2000 clamps to 1472; mac_exist dropping mid-request does not abort.
        tgt = frames + 1;
        start(16'h0F0F, 2000, 1);
        mac_exist = 1'b0;
        wait_frame(tgt, 400, 0);
        mac_exist = 1'b1;
        check("F_beats", last_beats, 185);
        exp_done_cyc = cyc + 1;
        reply(16'h0F0F, 16'h0003);
        tick(1);
        check("F_rtt", ping_rtt, 1);

        // Reset mid-SEND drops the frame; next start produces a clean frame.
        t0 = cyc;
        start(16'h4242, 40, 1);
        wait_tvalid("G_first_tvalid", t0, 7);
        tick(2);
        rst_n = 1'b0;
        #1;
        check("G_rst_tvalid", tvalid, 0);
        check("G_rst_tdata", tdata, 0);
        check("G_rst_tkeep", tkeep, 0);
        check("G_rst_busy", ping_busy, 0);
        check("G_rst_seq", ping_seq, 0);
        m_seq = '0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("G_no_residue", tvalid, 0);
        tgt = frames + 1;
        start(16'h4242, 13, 1);
        wait_frame(tgt, 50, 0);
        check("G_beats", last_beats, 3);
        exp_done_cyc = cyc + 1;
        reply(16'h4242, 16'h0000);
        tick(2);
        check("G_rtt", ping_rtt, 1);
        check("G_queue_empty", q_data.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
